// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one I2C engine among NUM_REQ requesters
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   - WAIT_DONE is bounded by TIMEOUT_CYC cycles; on expiry m_abort pulses
//               and the requester gets an error response
//   undefined - WAIT_DONE waits for m_done indefinitely; m_abort is tied 0
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   req_valid/req_ready            per-requester request / one-hot grant
//   req_rw, req_addr, req_wdata    per-requester fields (7-bit addr, 8-bit data slices)
//   rsp_valid, rsp_rdata, rsp_err  one-hot completion pulse, read byte, NACK/timeout flag
//   m_start, m_rw, m_addr, m_wdata engine command
//   m_done, m_ack_err, m_rdata     engine completion
//   m_abort                        engine abort pulse (timeout build only)
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ*7-1:0]   req_addr,
    input  logic [NUM_REQ*8-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_wdata,
    input  logic                   m_done,
    input  logic                   m_ack_err,
    input  logic [7:0]             m_rdata,
    output logic                   m_abort
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             gnt_found;
    logic             cur_rw;
    logic [6:0]       cur_addr;
    logic [7:0]       cur_wdata;
    logic             timeout_hit;

    // Search upward from rr_ptr with wrap; first asserted req_valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    // Cleared in ISSUE so the first WAIT_DONE cycle sees 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (gnt_found) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (m_done || timeout_hit) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        m_start   = 1'b0;
        m_abort   = 1'b0;
        case (state)
            IDLE:      if (gnt_found) req_ready = ONE << gnt_idx;
            ISSUE:     m_start = 1'b1;
            WAIT_DONE: m_abort = timeout_hit && !m_done;  // m_done wins a tie
            RESP:      rsp_valid = ONE << grant;
            default:   ;
        endcase
    end

    // Transaction fields and response registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            grant     <= '0;
            cur_rw    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        grant     <= gnt_idx;
                        cur_rw    <= req_rw[gnt_idx];
                        cur_addr  <= req_addr[int'(gnt_idx)*7 +: 7];
                        cur_wdata <= req_wdata[int'(gnt_idx)*8 +: 8];
                    end
                end
                WAIT_DONE: begin
                    if (m_done) begin
                        rsp_rdata <= cur_rw ? m_rdata : 8'h00;
                        rsp_err   <= m_ack_err;
                    end else if (timeout_hit) begin
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_rw    = cur_rw;
    assign m_addr  = cur_addr;
    assign m_wdata = cur_wdata;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

    localparam int NR = 4;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int W_DELAY    = 10;
    localparam int EXP_ABORTS = 1;
`else
    localparam int W_DELAY    = 40;
    localparam int EXP_ABORTS = 0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_rw;
    logic [NR*7-1:0]   req_addr;
    logic [NR*8-1:0]   req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              m_start;
    logic              m_rw;
    logic [6:0]        m_addr;
    logic [7:0]        m_wdata;
    logic              m_done;
    logic              m_ack_err;
    logic [7:0]        m_rdata;
    logic              m_abort;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    int   rsp_cnt = 0;
    int   abort_cnt = 0;

    i2c_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_ack_err(m_ack_err), .m_rdata(m_rdata),
        .m_abort(m_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every response pulse is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (m_start === 1'b1) start_cnt++;
        if (m_abort === 1'b1) abort_cnt++;
        if (resetn === 1'b1 && (|rsp_valid) === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_idx", 32'(rsp_valid), 32'(1 << e.idx));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_m_start"}, 32'(m_start), 32'h0);
        chk({tag, "_m_rw"}, 32'(m_rw), 32'h0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'h0);
        chk({tag, "_m_wdata"}, 32'(m_wdata), 32'h0);
        chk({tag, "_m_abort"}, 32'(m_abort), 32'h0);
    endtask

    // One transaction: present valids, expect grant g, engine completes
    // 'delay' cycles after m_start (m_done lands on WAIT_DONE cycle delay-1).
    task automatic issue_one(input logic [NR-1:0] valids, input int g, input bit hold,
                             input int delay, input logic [7:0] rd, input logic er);
        exp_t e;
        @(negedge clk);
        req_valid = valids;
        #1;
        chk("ready", 32'(req_ready), 32'(1 << g));
        e.idx   = g;
        e.rdata = req_rw[g] ? rd : 8'h00;
        e.err   = er;
        exp_q.push_back(e);
        @(negedge clk);
        chk("m_start", 32'(m_start), 32'h1);
        chk("m_addr", 32'(m_addr), 32'(req_addr[7*g +: 7]));
        chk("m_wdata", 32'(m_wdata), 32'(req_wdata[8*g +: 8]));
        chk("m_rw", 32'(m_rw), 32'(req_rw[g]));
        chk("ready_busy", 32'(req_ready), 32'h0);
        if (!hold) req_valid = '0;
        repeat (delay) @(negedge clk);
        chk("m_addr_hold", 32'(m_addr), 32'(req_addr[7*g +: 7]));
        m_done    = 1'b1;
        m_rdata   = rd;
        m_ack_err = er;
        #1;
        chk("abort_on_done", 32'(m_abort), 32'h0);
        @(negedge clk);
        m_done    = 1'b0;
        m_ack_err = 1'b0;
        m_rdata   = 8'(rd + 8'h11);
        chk("rsp_lat", 32'(rsp_valid), 32'(1 << g));
        chk("m_wdata_resp", 32'(m_wdata), 32'(req_wdata[8*g +: 8]));
        chk("m_start_resp", 32'(m_start), 32'h0);
    endtask

    initial begin
        int s0;
        int r0;
        req_valid = '0;
        req_rw    = 4'b0101;
        req_addr  = {7'h13, 7'h12, 7'h50, 7'h3C};
        req_wdata = {8'hC3, 8'hC2, 8'hA5, 8'hC0};
        m_done    = 1'b0;
        m_ack_err = 1'b0;
        m_rdata   = 8'h00;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst0");
        resetn = 1'b1;

        // Single write from requester 1
        issue_one(4'b0010, 1, 1'b0, W_DELAY, 8'hDE, 1'b0);

        // m_done while IDLE must not produce a response
        @(negedge clk);
        m_done = 1'b1; m_rdata = 8'hEE; m_ack_err = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_ack_err = 1'b0;
        @(negedge clk);
        chk("idle_done_err", 32'(rsp_err), 32'h0);
        chk("idle_done_rdata", 32'(rsp_rdata), 32'h0);

        // Read with NACK from requester 0 (rr_ptr=2, wraps to 0)
        issue_one(4'b0001, 0, 1'b0, 3, 8'h77, 1'b1);
        // rr_ptr=1 -> grant 2 -> rr_ptr=3
        issue_one(4'b0100, 2, 1'b0, 2, 8'h5A, 1'b0);
        // rr_ptr=3, only requester 0 -> wrap grant 0, rr_ptr=1
        issue_one(4'b0001, 0, 1'b0, 2, 8'h31, 1'b0);
        // all requesting: rr_ptr=1 must pick 1
        issue_one(4'b1111, 1, 1'b0, 2, 8'h00, 1'b0);

        // Round-robin from reset with all valids held
        do_reset();
        s0 = start_cnt;
        r0 = rsp_cnt;
        issue_one(4'b1111, 0, 1'b1, 4, 8'h10, 1'b0);
        issue_one(4'b1111, 1, 1'b1, 4, 8'h11, 1'b0);
        issue_one(4'b1111, 2, 1'b1, 4, 8'h12, 1'b0);
        issue_one(4'b1111, 3, 1'b1, 4, 8'h13, 1'b0);
        issue_one(4'b1111, 0, 1'b0, 4, 8'h99, 1'b1);
        @(negedge clk);
        chk("rr_starts", 32'(start_cnt - s0), 32'd5);
        chk("rr_rsps", 32'(rsp_cnt - r0), 32'd5);

        // Reset while waiting for the engine
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        chk("pre_rst_start", 32'(m_start), 32'h1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outputs("rst_wait");
        resetn = 1'b1;
        r0 = rsp_cnt;
        @(negedge clk);
        m_done = 1'b1; m_rdata = 8'h66;
        @(negedge clk);
        m_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'h0);

`ifdef I2C_ARB_TIMEOUT_EN
        // No m_done: abort on the 16th WAIT_DONE cycle
        begin
            exp_t e;
            @(negedge clk);
            req_valid = 4'b1000;
            e.idx = 3; e.rdata = 8'h00; e.err = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
            chk("to_start", 32'(m_start), 32'h1);
            req_valid = '0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                #1;
                chk("to_abort", 32'(m_abort), (k == 15) ? 32'h1 : 32'h0);
            end
            @(negedge clk);
            #1;
            chk("to_rsp", 32'(rsp_valid), 32'h8);
            chk("to_abort_after", 32'(m_abort), 32'h0);
        end
        // m_done on the last allowed cycle wins
        issue_one(4'b0001, 0, 1'b0, 16, 8'h42, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("abort_count", 32'(abort_cnt), 32'(EXP_ABORTS));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4, number of requesters (2..8).
- TIMEOUT_CYC, default 2048, clk cycles allowed per transaction before abort.
REQ-002 Clock and reset SHALL be one clock; reset is synchronous and active-low:
- clk  in  1  system clock (100 MHz).
- resetn  in  1  synchronous active-low reset.
REQ-003 Requester-side ports SHALL be:
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*7  7-bit target address per requester, requester i at bits [7i+6:7i].
- req_wdata  in  NUM_REQ*8  write byte per requester, requester i at bits [8i+7:8i].
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  8  read byte of the completed transaction.
- rsp_err  out  1  NACK or timeout on the completed transaction.
REQ-004 Engine-side ports SHALL be:
- m_start  out  1  one-cycle start pulse to the I2C engine.
- m_rw  out  1  transaction direction.
- m_addr  out  7  target address.
- m_wdata  out  8  write byte.
- m_done  in  1  engine completion pulse.
- m_ack_err  in  1  engine NACK flag, valid with m_done.
- m_rdata  in  8  engine read byte, valid with m_done.
- m_abort  out  1  one-cycle engine abort pulse.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RESP, with one transaction outstanding at most.
REQ-006 In IDLE, req_ready SHALL be combinational and one-hot on the first asserted req_valid at or after rr_ptr, searching upward with wrap to 0; it SHALL be all-zero when no req_valid is asserted or the state is not IDLE.
REQ-007 On a req_valid&req_ready handshake, the grant index, rw, addr and wdata SHALL be registered and the state SHALL move to ISSUE.
REQ-008 In ISSUE, m_start SHALL be 1 for exactly one cycle with m_rw, m_addr and m_wdata driven from the registered fields, and the next state SHALL be WAIT_DONE.
REQ-009 m_rw, m_addr and m_wdata SHALL hold stable from ISSUE through RESP.
REQ-010 In WAIT_DONE on m_done=1, m_rdata and m_ack_err SHALL be registered into rsp_rdata and rsp_err, and the next state SHALL be RESP.
REQ-011 m_done SHALL be ignored outside WAIT_DONE.
REQ-012 In RESP, rsp_valid[grant] SHALL be 1 for exactly one cycle and rr_ptr SHALL become (grant+1) mod NUM_REQ, with NUM_REQ-1 wrapping to 0; the next state SHALL be IDLE.
REQ-013 rsp_rdata SHALL be 0 on write transactions; rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-014 Minimum latency SHALL be: handshake cycle T, m_start at T+1, rsp_valid one cycle after the m_done cycle.
REQ-015 A requester deasserting req_valid before it is granted SHALL be legal and SHALL NOT change rr_ptr.
REQ-016 req_valid and the requester fields SHALL be sampled only in the handshake cycle.

Reset
REQ-017 On resetn=0 at a clk edge, the state SHALL be IDLE and rr_ptr 0; req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata and m_abort SHALL all be 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction without a rsp_valid pulse and without an m_abort pulse.

Configuration
REQ-019 With macro I2C_ARB_TIMEOUT_EN defined, a timeout counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle.
REQ-020 With I2C_ARB_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYC-1 without m_done: m_abort SHALL pulse for one cycle, rsp_err SHALL be 1, rsp_rdata SHALL be 0, and the next state SHALL be RESP.
REQ-021 If m_done and the timeout occur in the same cycle, m_done SHALL win and m_abort SHALL stay 0.
REQ-022 With I2C_ARB_TIMEOUT_EN undefined, no counter SHALL exist, m_abort SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely for m_done.

Verification
REQ-023 Single write: req_valid[1]=1, rw=0, addr=0x50, wdata=0xA5 -> m_start one cycle later with m_addr=0x50 and m_wdata=0xA5; m_done 40 cycles later -> rsp_valid=4'b0010, rsp_err=0.
REQ-024 Read with NACK: requester 0 reads addr 0x3C; engine returns m_rdata=0x77 with m_ack_err=1 -> rsp_rdata=0x77, rsp_err=1.
REQ-025 Round-robin: all four req_valid held high -> grants in order 0,1,2,3,0, with exactly one m_start per completed rsp_valid.
REQ-026 Wrap: rr_ptr=3, only req_valid[0] asserted -> requester 0 granted; the next rr_ptr is 1.
REQ-027 Timeout (I2C_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16): no m_done -> m_abort pulse and rsp_err=1 exactly 16 cycles after entering WAIT_DONE; m_done on cycle 15 -> normal response with m_abort=0.
REQ-028 Reset in WAIT_DONE: resetn=0 for one cycle -> all outputs 0 and state IDLE; a later m_done produces no rsp_valid.
